// File: rtl/vm_inventory_arbiter.sv
// Vending machine inventory store: per-item count and cost, shared by the
// query, dispense and restock paths through a round-robin req/ack arbiter.
module vm_inventory_arbiter #(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned COST_W    = 8,
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic                 clk,
    input  logic                 hrst,
    input  logic                 q_req,
    input  logic [2:0]           q_item,
    output logic                 q_ack,
    output logic [CNT_W-1:0]     q_count,
    output logic [COST_W-1:0]    q_cost,
    input  logic                 d_req,
    input  logic [2:0]           d_item,
    output logic                 d_ack,
    output logic                 d_ok,
    output logic [COST_W-1:0]    d_cost,
    input  logic                 r_req,
    input  logic [2:0]           r_item,
    input  logic [CNT_W-1:0]     r_count,
    input  logic [COST_W-1:0]    r_cost,
    output logic                 r_ack,
    output logic                 r_err,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] empty_mask
);

    localparam int unsigned ITEM_W = 3;
    localparam int unsigned SLOTS  = 1 << ITEM_W;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam logic [SLOTS-1:0] VALID_MASK = SLOTS'((64'd1 << NUM_ITEMS) - 64'd1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RESP} state_t;
    typedef enum logic [1:0] {SRC_D, SRC_R, SRC_Q} src_t;

    state_t              state;
    src_t                ptr;
    src_t                lat_src;
    logic [ITEM_W-1:0]   lat_item;
    logic [CNT_W-1:0]    lat_count;
    logic [COST_W-1:0]   lat_cost;
    logic [CNT_W-1:0]    count_mem [SLOTS];
    logic [COST_W-1:0]   cost_mem  [SLOTS];

    src_t                win;
    src_t                next_ptr;
    logic                win_valid;
    logic [ITEM_W-1:0]   sel_item;
    logic [CNT_W-1:0]    sel_count;
    logic [COST_W-1:0]   sel_cost;

    logic                item_valid;
    logic [CNT_W-1:0]    cur_count;
    logic [COST_W-1:0]   cur_cost;
    logic [SUM_W-1:0]    sum;
    logic                restock_ok;
    logic                dispense_ok;

    // Round-robin pick starting at ptr: D -> R -> Q -> D.
    always_comb begin
        win_valid = d_req | r_req | q_req;
        win       = SRC_D;
        case (ptr)
            SRC_D: begin
                if (d_req)      win = SRC_D;
                else if (r_req) win = SRC_R;
                else if (q_req) win = SRC_Q;
            end
            SRC_R: begin
                if (r_req)      win = SRC_R;
                else if (q_req) win = SRC_Q;
                else if (d_req) win = SRC_D;
            end
            default: begin
                if (q_req)      win = SRC_Q;
                else if (d_req) win = SRC_D;
                else if (r_req) win = SRC_R;
            end
        endcase
    end

    always_comb begin
        sel_item  = q_item;
        sel_count = '0;
        sel_cost  = '0;
        next_ptr  = SRC_D;
        case (win)
            SRC_D: begin
                sel_item = d_item;
                next_ptr = SRC_R;
            end
            SRC_R: begin
                sel_item  = r_item;
                sel_count = r_count;
                sel_cost  = r_cost;
                next_ptr  = SRC_Q;
            end
            default: next_ptr = SRC_D;
        endcase
    end

    // Operation result for the latched request, evaluated during GRANT.
    always_comb begin
        item_valid  = VALID_MASK[lat_item];
        cur_count   = count_mem[lat_item];
        cur_cost    = cost_mem[lat_item];
        sum         = SUM_W'(cur_count) + SUM_W'(lat_count);
        restock_ok  = item_valid && (sum <= SUM_W'(MAX_COUNT));
        dispense_ok = item_valid && (cur_count != '0);
    end

    always_ff @(posedge clk) begin
        if (hrst) begin
            state      <= ST_IDLE;
            ptr        <= SRC_D;
            lat_src    <= SRC_D;
            lat_item   <= '0;
            lat_count  <= '0;
            lat_cost   <= '0;
            count_mem  <= '{default: '0};
            cost_mem   <= '{default: '0};
            q_ack      <= 1'b0;
            q_count    <= '0;
            q_cost     <= '0;
            d_ack      <= 1'b0;
            d_ok       <= 1'b0;
            d_cost     <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            busy       <= 1'b0;
            empty_mask <= '1;
        end else begin
            q_ack <= 1'b0;
            d_ack <= 1'b0;
            r_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state     <= ST_GRANT;
                        busy      <= 1'b1;
                        ptr       <= next_ptr;
                        lat_src   <= win;
                        lat_item  <= sel_item;
                        lat_count <= sel_count;
                        lat_cost  <= sel_cost;
                    end
                end
                ST_GRANT: begin
                    state <= ST_RESP;
                    case (lat_src)
                        SRC_D: begin
                            d_ack  <= 1'b1;
                            d_ok   <= dispense_ok;
                            d_cost <= dispense_ok ? cur_cost : '0;
                            if (dispense_ok) begin
                                count_mem[lat_item]  <= cur_count - CNT_W'(1);
                                empty_mask[lat_item] <= (cur_count == CNT_W'(1));
                            end
                        end
                        SRC_R: begin
                            r_ack <= 1'b1;
                            r_err <= ~restock_ok;
                            if (restock_ok) begin
                                count_mem[lat_item]  <= sum[CNT_W-1:0];
                                empty_mask[lat_item] <= (sum == '0);
                                if (lat_cost != '0) cost_mem[lat_item] <= lat_cost;
                            end
                        end
                        default: begin
                            q_ack   <= 1'b1;
                            q_count <= item_valid ? cur_count : '0;
                            q_cost  <= item_valid ? cur_cost : '0;
                        end
                    endcase
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_inventory_arbiter.sv
// Bench for vm_inventory_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized single operations against an inventory model.
module tb_vm_inventory_arbiter;

    localparam int unsigned NUM_ITEMS = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned COST_W    = 8;
    localparam int unsigned MAX_COUNT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 hrst;
    logic                 q_req, d_req, r_req;
    logic [2:0]           q_item, d_item, r_item;
    logic [CNT_W-1:0]     r_count;
    logic [COST_W-1:0]    r_cost;
    logic                 q_ack, d_ack, r_ack;
    logic [CNT_W-1:0]     q_count;
    logic [COST_W-1:0]    q_cost, d_cost;
    logic                 d_ok, r_err, busy;
    logic [NUM_ITEMS-1:0] empty_mask;

    vm_inventory_arbiter #(
        .NUM_ITEMS(NUM_ITEMS), .CNT_W(CNT_W), .COST_W(COST_W), .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk(clk), .hrst(hrst),
        .q_req(q_req), .q_item(q_item), .q_ack(q_ack), .q_count(q_count), .q_cost(q_cost),
        .d_req(d_req), .d_item(d_item), .d_ack(d_ack), .d_ok(d_ok), .d_cost(d_cost),
        .r_req(r_req), .r_item(r_item), .r_count(r_count), .r_cost(r_cost),
        .r_ack(r_ack), .r_err(r_err), .busy(busy), .empty_mask(empty_mask)
    );

    typedef struct {
        int         op;       // 0 dispense, 1 restock, 2 query
        logic [2:0] item;
        logic [3:0] cnt;
        logic [7:0] cost;
        logic       exp_flag; // d_ok or r_err
        logic [3:0] exp_count;
        logic [7:0] exp_cost;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    int m_count [8];
    int m_cost  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        hrst  = 1'b1;
        q_req = 1'b0; d_req = 1'b0; r_req = 1'b0;
        @(negedge clk);
        hrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_count[i] = 0;
            m_cost[i]  = 0;
        end
    endtask

    // One request from an idle arbiter; returns at the negedge where ack is seen.
    task automatic do_op(input int op, input logic [2:0] item, input logic [3:0] cnt,
                         input logic [7:0] cost, output int lat);
        logic got;
        @(negedge clk);
        case (op)
            0: begin d_req = 1'b1; d_item = item; end
            1: begin r_req = 1'b1; r_item = item; r_count = cnt; r_cost = cost; end
            default: begin q_req = 1'b1; q_item = item; end
        endcase
        got = 1'b0;
        lat = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = (op == 0) ? d_ack : (op == 1) ? r_ack : q_ack;
        end
        if (!got) chk("ack_timeout", 32'(got), 32'd1);
        chk("ack_onehot", 32'({q_ack, r_ack, d_ack}), 32'(1 << op));
        d_req = 1'b0; r_req = 1'b0; q_req = 1'b0;
    endtask

    function automatic logic [7:0] model_empty();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (m_count[i] == 0);
        return m;
    endfunction

    int         lat;
    int         order [$];
    logic       saw, reraise;
    int         op;
    logic [2:0] item;
    logic [3:0] cnt;
    logic [7:0] cost;
    logic       e_d_ok, e_r_err;
    logic [3:0] e_q_count;
    logic [7:0] e_q_cost, e_d_cost;
    int         sum;

    initial begin
        hrst = 1'b1;
        q_req = 1'b0; d_req = 1'b0; r_req = 1'b0;
        q_item = '0; d_item = '0; r_item = '0; r_count = '0; r_cost = '0;

        vecs[0]  = '{1, 3'd1, 4'd10, 8'h4B, 1'b0, 4'd0,  8'h00};
        vecs[1]  = '{2, 3'd1, 4'd0,  8'h00, 1'b0, 4'd10, 8'h4B};
        vecs[2]  = '{1, 3'd1, 4'd6,  8'h00, 1'b1, 4'd0,  8'h00};
        vecs[3]  = '{2, 3'd1, 4'd0,  8'h00, 1'b0, 4'd10, 8'h4B};
        vecs[4]  = '{1, 3'd1, 4'd5,  8'h00, 1'b0, 4'd0,  8'h00};
        vecs[5]  = '{2, 3'd1, 4'd0,  8'h00, 1'b0, 4'd15, 8'h4B};
        vecs[6]  = '{1, 3'd3, 4'd0,  8'h32, 1'b0, 4'd0,  8'h00};
        vecs[7]  = '{2, 3'd3, 4'd0,  8'h00, 1'b0, 4'd0,  8'h32};
        vecs[8]  = '{1, 3'd3, 4'd3,  8'h00, 1'b0, 4'd0,  8'h00};
        vecs[9]  = '{2, 3'd3, 4'd0,  8'h00, 1'b0, 4'd3,  8'h32};
        vecs[10] = '{0, 3'd3, 4'd0,  8'h00, 1'b1, 4'd0,  8'h32};
        vecs[11] = '{1, 3'd7, 4'd15, 8'h01, 1'b0, 4'd0,  8'h00};
        vecs[12] = '{0, 3'd7, 4'd0,  8'h00, 1'b1, 4'd0,  8'h01};
        vecs[13] = '{0, 3'd5, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00};

        // Reset state, then first query latency and busy window.
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({q_ack, r_ack, d_ack}), 32'd0);
        chk("rst_empty", 32'(empty_mask), 32'hFF);
        chk("rst_outs", 32'({q_count, q_cost, d_ok, d_cost, r_err}), 32'd0);
        @(negedge clk);
        q_req = 1'b1; q_item = 3'd2;
        @(negedge clk);
        chk("lat_grant_busy", 32'(busy), 32'd1);
        chk("lat_grant_ack", 32'(q_ack), 32'd0);
        @(negedge clk);
        chk("lat_resp_ack", 32'(q_ack), 32'd1);
        chk("lat_resp_busy", 32'(busy), 32'd1);
        chk("lat_q_count", 32'(q_count), 32'd0);
        chk("lat_q_cost", 32'(q_cost), 32'd0);
        chk("lat_empty", 32'(empty_mask), 32'hFF);
        q_req = 1'b0;
        @(negedge clk);
        chk("lat_ack_pulse", 32'(q_ack), 32'd0);
        chk("lat_idle_busy", 32'(busy), 32'd0);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].op, vecs[i].item, vecs[i].cnt, vecs[i].cost, lat);
            chk("vec_latency", 32'(lat), 32'd2);
            case (vecs[i].op)
                0: begin
                    chk("vec_d_ok", 32'(d_ok), 32'(vecs[i].exp_flag));
                    chk("vec_d_cost", 32'(d_cost), 32'(vecs[i].exp_cost));
                end
                1: chk("vec_r_err", 32'(r_err), 32'(vecs[i].exp_flag));
                default: begin
                    chk("vec_q_count", 32'(q_count), 32'(vecs[i].exp_count));
                    chk("vec_q_cost", 32'(q_cost), 32'(vecs[i].exp_cost));
                end
            endcase
        end
        chk("vec_empty", 32'(empty_mask), 32'h75);

        // Drain 10 units of item 1, then one more.
        do_reset();
        do_op(1, 3'd1, 4'd10, 8'h4B, lat);
        chk("drain_restock", 32'(r_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            do_op(0, 3'd1, 4'd0, 8'h00, lat);
            chk("drain_d_ok", 32'(d_ok), 32'd1);
            chk("drain_d_cost", 32'(d_cost), 32'h4B);
        end
        chk("drain_empty_bit", 32'(empty_mask[1]), 32'd1);
        do_op(0, 3'd1, 4'd0, 8'h00, lat);
        chk("drain_11_ok", 32'(d_ok), 32'd0);
        chk("drain_11_cost", 32'(d_cost), 32'd0);

        // Round robin: all three pending from reset.
        do_reset();
        @(negedge clk);
        d_req = 1'b1; r_req = 1'b1; q_req = 1'b1;
        d_item = '0; r_item = '0; q_item = '0; r_count = '0; r_cost = '0;
        order.delete();
        for (int c = 0; c < 40 && order.size() < 3; c++) begin
            @(negedge clk);
            if (d_ack) begin order.push_back(0); d_req = 1'b0; end
            if (r_ack) begin order.push_back(1); r_req = 1'b0; end
            if (q_ack) begin order.push_back(2); q_req = 1'b0; end
        end
        chk("rr1_count", 32'(order.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("rr1_order", 32'((i < order.size()) ? order[i] : 7), 32'(i));

        // Round robin with dispense re-raised after each of its grants.
        do_reset();
        @(negedge clk);
        d_req = 1'b1; r_req = 1'b1; q_req = 1'b1;
        order.delete();
        reraise = 1'b0;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            @(negedge clk);
            if (reraise) begin d_req = 1'b1; reraise = 1'b0; end
            if (d_ack) begin order.push_back(0); d_req = 1'b0; reraise = 1'b1; end
            if (r_ack) begin order.push_back(1); r_req = 1'b0; end
            if (q_ack) begin order.push_back(2); q_req = 1'b0; end
        end
        d_req = 1'b0; r_req = 1'b0; q_req = 1'b0;
        chk("rr2_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("rr2_order", 32'((i < order.size()) ? order[i] : 7), 32'(i % 3));

        // Reset landing on the GRANT cycle of a dispense.
        do_reset();
        do_op(1, 3'd2, 4'd5, 8'h10, lat);
        @(negedge clk);
        d_req = 1'b1; d_item = 3'd2;
        @(negedge clk);
        chk("hrst_busy_grant", 32'(busy), 32'd1);
        hrst = 1'b1;
        d_req = 1'b0;
        saw = 1'b0;
        @(negedge clk);
        saw = saw | d_ack;
        hrst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw = saw | d_ack;
        end
        chk("hrst_no_ack", 32'(saw), 32'd0);
        chk("hrst_busy", 32'(busy), 32'd0);
        chk("hrst_empty", 32'(empty_mask), 32'hFF);
        do_op(2, 3'd2, 4'd0, 8'h00, lat);
        chk("hrst_q_count", 32'(q_count), 32'd0);
        chk("hrst_q_cost", 32'(q_cost), 32'd0);

        // Randomized single operations against the inventory model.
        do_reset();
        e_q_count = '0; e_q_cost = '0; e_d_ok = 1'b0; e_d_cost = '0; e_r_err = 1'b0;
        for (int n = 0; n < 400; n++) begin
            op   = int'($urandom_range(0, 2));
            item = 3'($urandom_range(0, 7));
            cnt  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
            cost = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            case (op)
                0: begin
                    if (int'(item) < NUM_ITEMS && m_count[item] > 0) begin
                        e_d_ok   = 1'b1;
                        e_d_cost = 8'(m_cost[item]);
                        m_count[item] = m_count[item] - 1;
                    end else begin
                        e_d_ok   = 1'b0;
                        e_d_cost = 8'h00;
                    end
                end
                1: begin
                    sum = m_count[item] + int'(cnt);
                    if (int'(item) >= NUM_ITEMS || sum > int'(MAX_COUNT)) begin
                        e_r_err = 1'b1;
                    end else begin
                        e_r_err = 1'b0;
                        m_count[item] = sum;
                        if (cost != 8'h00) m_cost[item] = int'(cost);
                    end
                end
                default: begin
                    e_q_count = (int'(item) < NUM_ITEMS) ? 4'(m_count[item]) : 4'd0;
                    e_q_cost  = (int'(item) < NUM_ITEMS) ? 8'(m_cost[item]) : 8'd0;
                end
            endcase
            do_op(op, item, cnt, cost, lat);
            chk("rnd_latency", 32'(lat), 32'd2);
            chk("rnd_q_count", 32'(q_count), 32'(e_q_count));
            chk("rnd_q_cost", 32'(q_cost), 32'(e_q_cost));
            chk("rnd_d_ok", 32'(d_ok), 32'(e_d_ok));
            chk("rnd_d_cost", 32'(d_cost), 32'(e_d_cost));
            chk("rnd_r_err", 32'(r_err), 32'(e_r_err));
            chk("rnd_empty", 32'(empty_mask), 32'(model_empty()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
